// File: rtl/div_pkg.sv
// Shared definitions for the pipelined restoring array divider.
package div_pkg;

    typedef enum logic [1:0] {
        SpNone,
        SpDivZero,
        SpOverflow
    } special_e;

    function automatic int unsigned mask_popcount(input logic [63:0] mask);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n += 32'(mask[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/div_row_stage.sv
// One combinational restoring-division row: shift in a dividend bit, compare, subtract.
module div_row_stage #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned BIT_POS   = 0
) (
    input  logic [DATAWIDTH-1:0] rem_in,
    input  logic [DATAWIDTH-1:0] quo_in,
    input  logic [DATAWIDTH-1:0] dvd,
    input  logic [DATAWIDTH-1:0] dvs,
    output logic [DATAWIDTH-1:0] rem_out,
    output logic [DATAWIDTH-1:0] quo_out
);

    logic [DATAWIDTH:0] shifted;
    logic [DATAWIDTH:0] diff;
    logic               take;

    // Compare at DATAWIDTH+1 bits so the shifted-out remainder MSB is kept.
    always_comb begin
        shifted = {rem_in, dvd[BIT_POS]};
        diff    = shifted - {1'b0, dvs};
        take    = (shifted >= {1'b0, dvs});
        rem_out = take ? diff[DATAWIDTH-1:0] : shifted[DATAWIDTH-1:0];
        quo_out = {quo_in[DATAWIDTH-2:0], take};
    end

    logic unused_bits;
    assign unused_bits = ^{quo_in[DATAWIDTH-1], diff[DATAWIDTH], dvd};

endmodule

// File: rtl/pipelined_array_divider.sv
// Restoring array divider with mask-placed register slices, signed mode,
// special-case flags and a global-stall valid/ready handshake.
module pipelined_array_divider
    import div_pkg::*;
#(
    parameter int unsigned          DATAWIDTH   = 8,
    parameter logic [DATAWIDTH:0]   PIPE_MASK   = {(DATAWIDTH+1){1'b1}},
    parameter int unsigned          INSTANCE_ID = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_signed,
    input  logic [DATAWIDTH-1:0] A,
    input  logic [DATAWIDTH-1:0] B,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DATAWIDTH-1:0] Q_out,
    output logic [DATAWIDTH-1:0] R_out,
    output logic                 o_div_by_zero,
    output logic                 o_overflow
);

    localparam int unsigned    DW      = DATAWIDTH;
    localparam int unsigned    LATENCY = mask_popcount(64'(PIPE_MASK));
    localparam logic [DW-1:0]  MIN_VAL = {1'b1, {(DW-1){1'b0}}};

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] rem;
        logic [DW-1:0] quo;
        logic [DW-1:0] dvd;
        logic [DW-1:0] dvs;
        logic          qsign;
        logic          rsign;
        logic          dbz;
        logic          ovf;
    } div_slice_t;

    logic       advance;
    logic       a_neg;
    logic       b_neg;
    special_e   special;
    div_slice_t pre;
    div_slice_t last;
    div_slice_t post_res;
    div_slice_t res;

    assign advance = ~o_valid | i_ready;
    assign o_ready = (LATENCY == 0) ? i_ready : advance;

    always_comb begin
        a_neg   = i_signed & A[DW-1];
        b_neg   = i_signed & B[DW-1];
        special = SpNone;
        if (B == '0) begin
            special = SpDivZero;
        end else if (i_signed && (A == MIN_VAL) && (B == '1)) begin
            special = SpOverflow;
        end
        pre       = '0;
        pre.valid = i_valid;
        pre.dvd   = a_neg ? -A : A;
        pre.dvs   = b_neg ? -B : B;
        pre.qsign = i_signed & (A[DW-1] ^ B[DW-1]);
        pre.rsign = a_neg;
        pre.dbz   = i_valid & (special == SpDivZero);
        pre.ovf   = i_valid & (special == SpOverflow);
    end

    for (genvar k = 0; k <= DW; k++) begin : g_stage
        div_slice_t sin;
        div_slice_t sout;

        if (k == 0) begin : g_src
            assign sin = pre;
        end else if (k < DW) begin : g_src
            assign sin = g_stage[k-1].g_row.rout;
        end else begin : g_src
            assign sin = post_res;
        end

        if (PIPE_MASK[k]) begin : g_slice
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sout <= '0;
                end else if (advance) begin
                    sout <= sin;
                end
            end
        end else begin : g_slice
            assign sout = sin;
        end

        if (k < DW) begin : g_row
            div_slice_t    rout;
            logic [DW-1:0] rem_n;
            logic [DW-1:0] quo_n;

            div_row_stage #(
                .DATAWIDTH(DW),
                .BIT_POS  (DW - 1 - k)
            ) u_row (
                .rem_in (sout.rem),
                .quo_in (sout.quo),
                .dvd    (sout.dvd),
                .dvs    (sout.dvs),
                .rem_out(rem_n),
                .quo_out(quo_n)
            );

            always_comb begin
                rout     = sout;
                rout.rem = rem_n;
                rout.quo = quo_n;
            end
        end
    end

    assign last = g_stage[DW-1].g_row.rout;

    // Sign fix-up, then special cases override the array result.
    always_comb begin
        post_res     = last;
        post_res.quo = last.qsign ? -last.quo : last.quo;
        post_res.rem = last.rsign ? -last.rem : last.rem;
        if (last.dbz) begin
            post_res.quo = '1;
            post_res.rem = last.rsign ? -last.dvd : last.dvd;
        end else if (last.ovf) begin
            post_res.quo = MIN_VAL;
            post_res.rem = '0;
        end
    end

    assign res           = g_stage[DW].sout;
    assign o_valid       = res.valid;
    assign Q_out         = res.quo;
    assign R_out         = res.rem;
    assign o_div_by_zero = res.dbz;
    assign o_overflow    = res.ovf;

    logic        unused_fields;
    logic [31:0] unused_id;
    assign unused_fields = ^{res.dvd, res.dvs, res.qsign, res.rsign};
    assign unused_id     = 32'(INSTANCE_ID);

endmodule

// File: tb/tb_pipelined_array_divider.sv
// Directed and model-checked bench for the pipelined array divider at three mask settings.
module tb_pipelined_array_divider;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_sgn;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       out_ready;

    logic       d_ready, d_valid, d_dbz, d_ovf;
    logic [7:0] d_q, d_r;
    logic       t_ready, t_valid, t_dbz, t_ovf;
    logic [7:0] t_q, t_r;
    logic       c_ready, c_valid, c_dbz, c_ovf;
    logic [7:0] c_q, c_r;

    int checks;
    int failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipelined_array_divider #(.DATAWIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .i_valid(in_valid), .o_ready(d_ready), .i_signed(in_sgn),
        .A(in_a), .B(in_b), .o_valid(d_valid), .i_ready(out_ready), .Q_out(d_q),
        .R_out(d_r), .o_div_by_zero(d_dbz), .o_overflow(d_ovf)
    );

    pipelined_array_divider #(.DATAWIDTH(8), .PIPE_MASK(9'h101), .INSTANCE_ID(1)) u_two (
        .clk(clk), .rst(rst), .i_valid(in_valid), .o_ready(t_ready), .i_signed(in_sgn),
        .A(in_a), .B(in_b), .o_valid(t_valid), .i_ready(out_ready), .Q_out(t_q),
        .R_out(t_r), .o_div_by_zero(t_dbz), .o_overflow(t_ovf)
    );

    pipelined_array_divider #(.DATAWIDTH(8), .PIPE_MASK(9'h000), .INSTANCE_ID(2)) u_comb (
        .clk(clk), .rst(rst), .i_valid(in_valid), .o_ready(c_ready), .i_signed(in_sgn),
        .A(in_a), .B(in_b), .o_valid(c_valid), .i_ready(out_ready), .Q_out(c_q),
        .R_out(c_r), .o_div_by_zero(c_dbz), .o_overflow(c_ovf)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Packed as {dbz, ovf, q[7:0], r[7:0]}.
    function automatic logic [17:0] ref_div(input logic [7:0] a, input logic [7:0] b,
                                            input logic sgn);
        int         sa;
        int         sb;
        logic [7:0] q;
        logic [7:0] r;
        if (b == 8'h00) return {2'b10, 8'hFF, a};
        if (sgn && a == 8'h80 && b == 8'hFF) return {2'b01, 8'h80, 8'h00};
        if (sgn) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            q  = 8'(sa / sb);
            r  = 8'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {2'b00, q, r};
    endfunction

    task automatic run_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic sgn, input logic [7:0] eq, input logic [7:0] er,
                           input logic edbz, input logic eovf);
        logic [17:0] exp_v;
        int          lat_dut;
        int          lat_two;
        exp_v = {edbz, eovf, eq, er};
        @(posedge clk); #1;
        in_a = a; in_b = b; in_sgn = sgn; in_valid = 1'b1;
        #1;
        check_eq({tag, "_comb"}, 32'({c_valid, c_dbz, c_ovf, c_q, c_r}), 32'({1'b1, exp_v}));
        check_eq({tag, "_ready"}, 32'(d_ready), 32'd1);
        lat_dut = 0;
        lat_two = 0;
        for (int n = 1; n <= 30 && lat_dut == 0; n++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (t_valid && lat_two == 0) begin
                lat_two = n;
                check_eq({tag, "_two"}, 32'({t_dbz, t_ovf, t_q, t_r}), 32'(exp_v));
            end
            if (d_valid) begin
                lat_dut = n;
                check_eq({tag, "_dut"}, 32'({d_dbz, d_ovf, d_q, d_r}), 32'(exp_v));
            end
        end
        check_eq({tag, "_lat9"}, 32'(lat_dut), 32'd9);
        check_eq({tag, "_lat2"}, 32'(lat_two), 32'd2);
    endtask

    logic [16:0] bp_vec [12];
    logic [17:0] q_dut [$];
    logic [17:0] q_two [$];

    initial begin
        logic [17:0] held;
        logic [17:0] exp_now;
        int          in_idx;
        int          out_idx;
        int          stall_seen;
        int          extra;
        int          n;

        checks = 0; failures = 0;
        rst = 1'b0; in_valid = 1'b0; in_sgn = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        bp_vec = '{
            {1'b0, 8'd250, 8'd3},  {1'b1, 8'hF0, 8'h03}, {1'b0, 8'd17, 8'd17},
            {1'b1, 8'h7F, 8'hF9},  {1'b0, 8'd1, 8'd255}, {1'b1, 8'h80, 8'h02},
            {1'b0, 8'd99, 8'd0},   {1'b1, 8'h80, 8'hFF}, {1'b0, 8'd255, 8'd1},
            {1'b1, 8'hC8, 8'hE7},  {1'b0, 8'd0, 8'd5},   {1'b1, 8'h05, 8'h80}
        };

        #12;
        check_eq("reset_out", 32'({d_valid, d_dbz, d_ovf, d_q, d_r}), 32'd0);
        check_eq("reset_two", 32'({t_valid, t_dbz, t_ovf, t_q, t_r}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        run_one("u200_7", 8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0, 1'b0);
        run_one("dbz", 8'h55, 8'h00, 1'b0, 8'hFF, 8'h55, 1'b1, 1'b0);
        run_one("ovf", 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 1'b1);
        run_one("sdbz", 8'hF9, 8'h00, 1'b1, 8'hFF, 8'hF9, 1'b1, 1'b0);
        run_one("s_neg_neg", 8'hF9, 8'hFE, 1'b1, 8'h03, 8'hFF, 1'b0, 1'b0);

        // Signed back-to-back pair, results on consecutive cycles.
        @(posedge clk); #1;
        in_a = 8'hF9; in_b = 8'h02; in_sgn = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_a = 8'h07; in_b = 8'hFE;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 2;
        while (!d_valid && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("b2b_first", 32'({d_valid, d_dbz, d_ovf, d_q, d_r}), 32'({3'b100, 16'hFDFF}));
        check_eq("b2b_lat", 32'(n), 32'd9);
        @(posedge clk); #1;
        check_eq("b2b_second", 32'({d_valid, d_dbz, d_ovf, d_q, d_r}), 32'({3'b100, 16'hFD01}));

        // Backpressure stream with a 4-cycle stall in the middle.
        in_idx = 0; out_idx = 0; stall_seen = 0; held = '0;
        @(posedge clk); #1;
        for (int c = 0; c < 80 && out_idx < 12; c++) begin
            out_ready = !(c >= 12 && c < 16);
            in_valid  = (in_idx < 12);
            if (in_idx < 12) {in_sgn, in_a, in_b} = bp_vec[in_idx];
            @(negedge clk);
            if (!out_ready) begin
                check_eq("bp_stall_ready", 32'({d_ready, d_valid}), 32'b01);
                if (stall_seen != 0) begin
                    check_eq("bp_hold", 32'({d_dbz, d_ovf, d_q, d_r}), 32'(held));
                end
                held = {d_dbz, d_ovf, d_q, d_r};
                stall_seen = 1;
            end
            if (d_valid && out_ready) begin
                check_eq("bp_result", 32'({d_dbz, d_ovf, d_q, d_r}),
                         32'(ref_div(bp_vec[out_idx][15:8], bp_vec[out_idx][7:0],
                                     bp_vec[out_idx][16])));
                out_idx++;
            end
            if (in_valid && d_ready) in_idx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check_eq("bp_count_out", 32'(out_idx), 32'd12);
        check_eq("bp_count_in", 32'(in_idx), 32'd12);
        check_eq("bp_stalled", 32'(stall_seen), 32'd1);
        extra = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (d_valid) extra++;
        end
        check_eq("bp_no_dup", 32'(extra), 32'd0);

        // Reset with five operations in flight.
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            in_a = 8'(8'd40 + 8'(c)); in_b = 8'd3; in_sgn = 1'b0; in_valid = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_eq("rst_async", 32'({d_valid, d_dbz, d_ovf, d_q, d_r}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        extra = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (d_valid || t_valid) extra++;
        end
        check_eq("rst_no_stale", 32'(extra), 32'd0);
        run_one("after_rst", 8'd100, 8'd9, 1'b0, 8'd11, 8'd1, 1'b0, 1'b0);

        // Random sweep across all three latencies against the model.
        for (int c = 0; c < 10012; c++) begin
            @(posedge clk); #1;
            in_valid = (c < 10000);
            in_sgn   = 1'($urandom_range(0, 1));
            in_a     = 8'($urandom);
            in_b     = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 31) == 0) begin
                in_a = 8'h80; in_b = 8'hFF;
            end
            exp_now = ref_div(in_a, in_b, in_sgn);
            #1;
            if (in_valid) check_eq("sw_comb", 32'({c_dbz, c_ovf, c_q, c_r}), 32'(exp_now));
            @(negedge clk);
            if (d_valid) begin
                check_eq("sw_dut_pending", 32'(q_dut.size() > 0), 32'd1);
                if (q_dut.size() > 0)
                    check_eq("sw_dut", 32'({d_dbz, d_ovf, d_q, d_r}), 32'(q_dut.pop_front()));
            end
            if (t_valid) begin
                check_eq("sw_two_pending", 32'(q_two.size() > 0), 32'd1);
                if (q_two.size() > 0)
                    check_eq("sw_two", 32'({t_dbz, t_ovf, t_q, t_r}), 32'(q_two.pop_front()));
            end
            if (in_valid) begin
                q_dut.push_back(exp_now);
                q_two.push_back(exp_now);
            end
        end
        check_eq("sw_dut_drained", 32'(q_dut.size()), 32'd0);
        check_eq("sw_two_drained", 32'(q_two.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_array_divider.md
Name: pipelined_array_divider

Overview:
- Next-generation restoring array divider: DATAWIDTH rows of shift/compare/subtract, with register slices placed by a per-boundary bit mask.
- Adds runtime signed/unsigned mode, divide-by-zero and signed-overflow flags, and a valid/ready handshake with full-pipeline stall on downstream backpressure.
- Drop-in arithmetic unit for datapaths that need a parametrised-latency divider able to absorb backpressure.

Parameters:
- DATAWIDTH, 8: operand/result width, >= 2.
- PIPE_MASK, {(DATAWIDTH+1){1'b1}}: DATAWIDTH+1 bits.
  - Bit 0 = input slice before row 0.
  - Bit i (1..DATAWIDTH-1) = slice after row i-1.
  - Bit DATAWIDTH = output slice.
  - 1 = register, 0 = wire.
- INSTANCE_ID, 0: debug tag; no functional effect.

Ports:
- clk  input  1  clock, all flops rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset), synchronous deassert handled upstream.
- i_valid  input  1  input operands valid.
- o_ready  output  1  divider accepts input this cycle.
- i_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with A/B.
- A  input  DATAWIDTH  dividend.
- B  input  DATAWIDTH  divisor.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- Q_out  output  DATAWIDTH  quotient.
- R_out  output  DATAWIDTH  remainder.
- o_div_by_zero  output  1  result came from B == 0.
- o_overflow  output  1  signed MIN / -1 case.

Behaviour:
- Latency L = popcount(PIPE_MASK) cycles from accepted input to o_valid.
  - L = 0: fully combinational; o_valid = i_valid, o_ready = i_ready.
- Transfer rules:
  - Input transfer when i_valid & o_ready.
  - Output transfer when o_valid & i_ready.
- Global stall: advance = ~o_valid | i_ready.
  - Every enabled slice loads only when advance = 1.
  - o_ready = advance, combinational from i_ready; no bubble collapsing.
- Every slice carries: valid, partial remainder, partial quotient, dividend magnitude, divisor magnitude, sign-of-quotient, sign-of-remainder, dbz, ovf.
- Invalid entries still advance; their data is don't-care, but flags are gated by valid.
- Pre-processing (before row 0, combinational):
  - i_signed = 1: magnitudes = |A|, |B|; qsign = A[MSB]^B[MSB]; rsign = A[MSB].
  - i_signed = 0: magnitudes = A, B; both signs = 0.
- Row i:
  - Shift remainder left, inject dividend bit DATAWIDTH-1-i.
  - If shifted value >= divisor magnitude: subtract divisor and shift 1 into the quotient.
  - Otherwise: shift 0 into the quotient.
  - Remainder/quotient are DATAWIDTH bits; the compare uses DATAWIDTH+1 bits so no MSB is lost.
- Post-processing (after last row, before output slice):
  - Negate Q if qsign; negate R if rsign.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
- Special cases, override the array result:
  - B == 0: Q = all ones, R = A (unmodified), dbz = 1.
  - i_signed & A == MIN & B == all ones: Q = MIN, R = 0, ovf = 1.
  - The two are mutually exclusive.
- Reset (rst = 0, asynchronous):
  - o_valid = 0, Q_out = 0, R_out = 0, o_div_by_zero = 0, o_overflow = 0.
  - All slice valids and data = 0.
  - In-flight operations are discarded; nothing emerges after release.
- Simultaneous accept and emit in the same cycle with a full pipe: both occur, throughput is 1 per cycle.
- While stalled, all outputs hold stable.
- Mask change is elaboration-only. Results are identical for any PIPE_MASK; only latency differs.

Decomposition:
- Package div_pkg:
  - function mask_popcount(mask) for latency.
  - typedef div_slice_t struct (valid, rem, quo, dvd, dvs, qsign, rsign, dbz, ovf), parametrised through DATAWIDTH localparam in the module.
  - constants for special-case result codes.
- Sub-module div_row_stage:
  - One combinational restoring row, parameter BIT_POS.
  - Instantiated DATAWIDTH times in a generate loop.
- Slices: generate-if on PIPE_MASK bit, either an enabled register with async active-low reset or a pass-through wire.

Test Plan:
- Unsigned, DATAWIDTH=8, default mask: A=200, B=7, i_signed=0 -> Q_out=28, R_out=4, o_valid exactly 9 cycles after acceptance, flags 0.
- Signed, back-to-back:
  - -7 / 2 (A=0xF9, B=0x02) -> Q=0xFD, R=0xFF.
  - 7 / -2 (A=0x07, B=0xFE) -> Q=0xFD, R=0x01.
  - Results appear on consecutive cycles.
- Specials:
  - A=0x55, B=0, unsigned -> Q=0xFF, R=0x55, o_div_by_zero=1.
  - A=0x80, B=0xFF, signed -> Q=0x80, R=0x00, o_overflow=1, o_div_by_zero=0.
- Backpressure: stream 12 random operand pairs back-to-back, i_ready=0 for 4 cycles mid-stream.
  - o_ready=0 during the stall and outputs stable.
  - All 12 results emerge in order, none lost or duplicated.
  - Results match the reference model.
- Reset mid-flight: pull rst low with 5 operations in flight.
  - o_valid=0 and outputs 0 within the same cycle.
  - After release, no stale o_valid until a new input is accepted.
- Mask sweep:
  - PIPE_MASK=9'h000 -> same-cycle result 200/7=28 r4.
  - PIPE_MASK=9'h101 -> latency 2.
  - 10k random signed/unsigned operands match the reference model for each mask.
